pixel_read_arbiter: RTL and testbench
=====================================

# pixel_read_arbiter

Shares the single read port of the 1-bit-per-pixel image memory (80 bytes/row, 8 pixels/byte, LSB = lowest x) among N_REQ pixel requesters. Each requester presents (x, y) with a req/ack handshake and receives the pixel bit as a one-cycle valid pulse. Arbitration is round-robin. The block sits between the vision/overlay engines and the image memory, and replaces per-client ad-hoc read ports.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ROW_BYTES, 80, bytes per image row
- X_LIMIT, 640, first out-of-range x
- Y_LIMIT, 480, first out-of-range y

- clk  in  1  module clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  request per requester; held with x/y until ack
- x  in  10*N_REQ  requester i uses bits [10i+9:10i]
- y  in  10*N_REQ  requester i uses bits [10i+9:10i]
- ack  out  N_REQ  one-hot; combinational; high in the cycle requester i is accepted
- valid  out  N_REQ  one-hot registered pulse; result for requester i
- pixel  out  1  pixel bit; meaningful only while any valid bit is high
- invalidate  in  1  pulse on any image-memory write; used only with the cache
- rdaddress  out  16  memory read address (registered)
- rdata  in  8  memory data; valid in the 2nd cycle after rdaddress changes

## Operation
- Reset (reset=0, async): state=S_IDLE; ack=0 (forced low while reset is low); valid=0; pixel=0; rdaddress=0; rr_ptr=N_REQ-1; cache invalid. An in-flight request is dropped with no valid pulse; the requester re-requests.
- Round-robin: in S_IDLE, search from rr_ptr+1 upward with wrap. The first i with req[i]=1 is granted; ack[i]=1 that cycle; x/y/index are latched; rr_ptr<=i.
- Address: byte_addr = y*ROW_BYTES + (x>>3), computed at ≥17 bits and truncated to 16. The bit select is x[2:0].
- Out-of-range (x≥X_LIMIT or y≥Y_LIMIT): ack is granted. There is no memory access. The next cycle gives pixel=0 and valid[i]=1. State stays S_IDLE.
- Miss path states:
  - S_IDLE --grant--> S_ADDR, with rdaddress<=byte_addr.
  - S_ADDR --> S_DATA. The memory samples the address.
  - S_DATA: pixel<=rdata[xbit]; valid[i]<=1; state --> S_IDLE.
- S_ADDR/S_DATA: no grants; ack=0.
- valid is high only in the cycle after the S_DATA (or hit/out-of-range) edge. A new grant may occur in that same cycle.
- rdaddress holds its last value when idle.

## Timing
- Grant at cycle T. Miss gives valid at T+3; hit or out-of-range gives valid at T+1.
- Miss throughput: one request per 3 cycles. Hit/out-of-range throughput: one per cycle.
- A requester that drops req before ack is never granted; no valid is issued for it.
- x/y changes after ack are ignored.
- A requester holding req continuously gets at most one grant per full round when others are requesting.

## Configuration
- PIXEL_ARB_CACHE_EN defined:
  - A one-byte cache {cache_valid, cache_addr[15:0], cache_data[7:0]} is loaded at every S_DATA.
  - A grant whose byte_addr==cache_addr with cache_valid=1 is a hit: pixel<=cache_data[xbit], valid next cycle, stays S_IDLE.
  - invalidate=1 clears cache_valid at the next edge.
  - invalidate in the same cycle as a hit grant: treated as a miss.
  - invalidate during S_ADDR/S_DATA: the incoming byte is still returned to the requester, but cache_valid ends 0.
- Not defined: every in-range request takes the miss path; invalidate is ignored; no cache registers.

## Test plan
- Reset, then memory byte 1 = 8'h01 and req[0] with x=8, y=0 -> ack[0] at T, rdaddress=1 at T+1, valid[0]=1 and pixel=1 at T+3; x=9 -> pixel=0.
- req[0..3] all held high, each with a distinct address -> grant order 0,1,2,3,0; each ack spaced 3 cycles; every valid matches its requester.
- x=640, y=0 (and x=0, y=480) -> valid at T+1, pixel=0, rdaddress unchanged.
- reset driven low in S_ADDR -> all outputs 0 immediately; no valid after release; re-request returns the correct pixel.
- CACHE_EN: x=1, y=1 (byte 80 = 8'h02) miss, then x=2, y=1 -> second valid at T+1, pixel=0, no rdaddress change; then invalidate, then x=1, y=1 -> miss path, pixel=1 at T+3.
- Without CACHE_EN: the same sequence -> every request takes 3 cycles; invalidate has no effect.

Source files
------------

// File: rtl/pixel_read_arbiter.sv
// Round-robin share of the 1bpp image memory read port among N_REQ pixel requesters.
// Latency: miss = 3 cycles grant->valid, cache hit / out-of-range = 1 cycle.
// Backpressure: req held until the combinational ack; no grants while a miss is in flight. Cache: PIXEL_ARB_CACHE_EN.
module pixel_read_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ROW_BYTES = 80,
    parameter int X_LIMIT   = 640,
    parameter int Y_LIMIT   = 480
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [10*N_REQ-1:0] x,
    input  logic [10*N_REQ-1:0] y,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    valid,
    output logic                pixel,
    input  logic                invalidate,
    output logic [15:0]         rdaddress,
    input  logic [7:0]          rdata
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [10:0] X_LIM = 11'(X_LIMIT);
    localparam logic [10:0] Y_LIM = 11'(Y_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        xbit_q, xbit_d;
    logic [N_REQ-1:0]  valid_q, valid_d;
    logic              pixel_q, pixel_d;
    logic [15:0]       rdaddress_q, rdaddress_d;

    logic              found;
    logic              grant;
    logic [IDXW-1:0]   gnt_idx;
    logic [9:0]        x_sel;
    logic [9:0]        y_sel;
    logic [15:0]       byte_addr;
    logic              oor;
    logic              hit;
    logic              hit_bit;

    // Round-robin search: indices above rr_ptr first, then wrap to the low ones.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (j > int'(rr_ptr_q))) begin
                found   = 1'b1;
                gnt_idx = IDXW'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (j <= int'(rr_ptr_q))) begin
                found   = 1'b1;
                gnt_idx = IDXW'(j);
            end
        end
        x_sel = '0;
        y_sel = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (IDXW'(j) == gnt_idx) begin
                x_sel = x[10*j +: 10];
                y_sel = y[10*j +: 10];
            end
        end
        byte_addr = 16'(20'(y_sel) * 20'(ROW_BYTES) + 20'(x_sel[9:3]));
        oor       = ({1'b0, x_sel} >= X_LIM) || ({1'b0, y_sel} >= Y_LIM);
        grant     = reset && (state_q == S_IDLE) && found;
        ack       = '0;
        for (int j = 0; j < N_REQ; j++) begin
            ack[j] = grant && (IDXW'(j) == gnt_idx);
        end
    end

`ifdef PIXEL_ARB_CACHE_EN
    logic        cache_valid_q, cache_valid_d;
    logic [15:0] cache_addr_q, cache_addr_d;
    logic [7:0]  cache_data_q, cache_data_d;
    logic        inv_pend_q, inv_pend_d;

    assign hit     = grant && !oor && cache_valid_q && !invalidate && (byte_addr == cache_addr_q);
    assign hit_bit = cache_data_q[x_sel[2:0]];

    // A write seen while a miss is in flight may have changed the byte being fetched.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        inv_pend_d    = inv_pend_q;
        if (invalidate) begin
            cache_valid_d = 1'b0;
            if (state_q == S_ADDR) inv_pend_d = 1'b1;
        end
        if (state_q == S_DATA) begin
            cache_valid_d = !(invalidate || inv_pend_q);
            cache_addr_d  = rdaddress_q;
            cache_data_d  = rdata;
            inv_pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
            inv_pend_q    <= 1'b0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
            inv_pend_q    <= inv_pend_d;
        end
    end
`else
    logic inv_unused;
    assign inv_unused = invalidate;
    assign hit        = 1'b0;
    assign hit_bit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        xbit_d      = xbit_q;
        valid_d     = '0;
        pixel_d     = pixel_q;
        rdaddress_d = rdaddress_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    rr_ptr_d = gnt_idx;
                    idx_d    = gnt_idx;
                    xbit_d   = x_sel[2:0];
                    if (oor) begin
                        valid_d = ack;
                        pixel_d = 1'b0;
                    end else if (hit) begin
                        valid_d = ack;
                        pixel_d = hit_bit;
                    end else begin
                        rdaddress_d = byte_addr;
                        state_d     = S_ADDR;
                    end
                end
            end
            S_ADDR: state_d = S_DATA;
            S_DATA: begin
                pixel_d = rdata[xbit_q];
                for (int j = 0; j < N_REQ; j++) begin
                    valid_d[j] = (IDXW'(j) == idx_q);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= IDXW'(N_REQ - 1);
            idx_q       <= '0;
            xbit_q      <= '0;
            valid_q     <= '0;
            pixel_q     <= 1'b0;
            rdaddress_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            xbit_q      <= xbit_d;
            valid_q     <= valid_d;
            pixel_q     <= pixel_d;
            rdaddress_q <= rdaddress_d;
        end
    end

    assign valid     = valid_q;
    assign pixel     = pixel_q;
    assign rdaddress = rdaddress_q;

endmodule

// File: tb/tb_pixel_read_arbiter.sv
// Bench for pixel_read_arbiter: directed scenarios plus randomized requesters, scored against a queue-based model.
module tb_pixel_read_arbiter;
    localparam int N = 4;
`ifdef PIXEL_ARB_CACHE_EN
    localparam int HITLAT = 1;
`else
    localparam int HITLAT = 3;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [10*N-1:0] x, y;
    logic [N-1:0]    ack, valid;
    logic            pixel, invalidate;
    logic [15:0]     rdaddress;
    logic [7:0]      rdata;
    logic [7:0]      mem [0:65535];

    pixel_read_arbiter #(.N_REQ(N), .ROW_BYTES(80), .X_LIMIT(640), .Y_LIMIT(480)) dut (
        .clk(clk), .reset(reset), .req(req), .x(x), .y(y), .ack(ack), .valid(valid),
        .pixel(pixel), .invalidate(invalidate), .rdaddress(rdaddress), .rdata(rdata)
    );

    always #5 clk = ~clk;
    // Memory: data for an address appears in the second cycle after it is presented.
    always @(posedge clk) rdata <= mem[rdaddress];

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct { int idx; logic pix; longint due; logic [15:0] ra; } exp_t;
    exp_t        sq[$];
    longint      cyc = 0;
    int          m_rr = N - 1;
    longint      m_busy = 0;
    logic        m_cv = 1'b0;
    logic [15:0] m_ca = '0, m_last = '0;
    logic [N-1:0] ack_seen = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pick(input logic [N-1:0] r, input int rr);
        for (int k = 1; k <= N; k++) if (r[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // Reference model and monitor.
    always @(negedge clk) begin
        int g, xi, yi, a;
        logic oor, hit;
        logic [7:0] b;
        exp_t e;
        ack_seen = ack;
        if (!reset) begin
            sq.delete();
            m_rr = N - 1; m_busy = cyc; m_cv = 1'b0; m_last = '0;
            chk("rst_ack", ack, 0);
            chk("rst_valid", valid, 0);
            chk("rst_pixel", pixel, 0);
            chk("rst_rdaddress", rdaddress, 0);
        end else begin
            if (valid != 0 || (sq.size() > 0 && sq[0].due == cyc)) begin
                if (sq.size() == 0) chk("unexpected_valid", valid, 0);
                else begin
                    e = sq.pop_front();
                    chk("valid_onehot", valid, 1 << e.idx);
                    chk("valid_time", cyc, e.due);
                    chk("pixel", pixel, e.pix);
                    chk("rdaddress", rdaddress, e.ra);
                end
            end
            if (invalidate) m_cv = 1'b0;
            g = (cyc >= m_busy) ? pick(req, m_rr) : -1;
            chk("ack", ack, (g < 0) ? 0 : (1 << g));
            if (g >= 0) begin
                xi  = int'(x[10*g +: 10]);
                yi  = int'(y[10*g +: 10]);
                oor = (xi >= 640) || (yi >= 480);
                a   = (yi * 80 + xi / 8) % 65536;
                b   = mem[a];
`ifdef PIXEL_ARB_CACHE_EN
                hit = !oor && m_cv && (m_ca == 16'(a));
`else
                hit = 1'b0;
`endif
                e.idx = g;
                e.pix = oor ? 1'b0 : b[xi % 8];
                if (oor || hit) begin
                    e.due = cyc + 1; e.ra = m_last; m_busy = cyc + 1;
                end else begin
                    m_last = 16'(a);
                    e.due = cyc + 3; e.ra = 16'(a); m_busy = cyc + 3;
                    m_cv = 1'b1; m_ca = 16'(a);
                end
                sq.push_back(e);
                m_rr = g;
            end
        end
    end

    task automatic drain();
        int t = 0;
        while (sq.size() != 0 && t < 50) begin @(negedge clk); t++; end
        if (sq.size() != 0) chk("drain_timeout", sq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_inv();
        @(posedge clk); #1 invalidate = 1'b1;
        @(posedge clk); #1 invalidate = 1'b0;
    endtask

    // One request from requester i; reports grant->valid latency and the returned pixel.
    task automatic one(input int i, input int xi, input int yi, output int lat, output logic pix);
        int t = 0;
        @(posedge clk); #1;
        x[10*i +: 10] = 10'(xi); y[10*i +: 10] = 10'(yi); req[i] = 1'b1;
        @(negedge clk);
        while (!ack[i] && t < 20) begin @(negedge clk); t++; end
        if (!ack[i]) chk("ack_timeout", 0, 1);
        lat = 0; pix = 1'b0;
        @(posedge clk); #1 req[i] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (valid[i]) begin lat = k; pix = pixel; break; end
        end
        drain();
    endtask

    task automatic new_xy(input int i);
        int r = $urandom_range(0, 99);
        int xi = $urandom_range(0, 639), yi = $urandom_range(0, 479);
        if (r < 40)      begin xi = $urandom_range(0, 15); yi = 1; end
        else if (r < 50) xi = $urandom_range(640, 700);
        else if (r < 55) yi = $urandom_range(480, 600);
        x[10*i +: 10] = 10'(xi); y[10*i +: 10] = 10'(yi);
    endtask

    initial begin
        int lat, seen, ng;
        logic pix;
        int gord[$];
        longint gcyc[$];
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        reset = 1'b0; req = '0; x = '0; y = '0; invalidate = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        mem[1] = 8'h01; mem[80] = 8'h02;
        pulse_inv();
        one(0, 8, 0, lat, pix);   chk("t1_lat", lat, 3);          chk("t1_pix", pix, 1);
        chk("t1_rdaddress", rdaddress, 1);
        one(0, 9, 0, lat, pix);   chk("t1b_lat", lat, HITLAT);    chk("t1b_pix", pix, 0);
        one(1, 640, 0, lat, pix); chk("oorx_lat", lat, 1);        chk("oorx_pix", pix, 0);
        chk("oorx_rdaddress", rdaddress, 1);
        one(2, 0, 480, lat, pix); chk("oory_lat", lat, 1);        chk("oory_pix", pix, 0);
        chk("oory_rdaddress", rdaddress, 1);

        one(3, 1, 1, lat, pix);   chk("c1_lat", lat, 3);          chk("c1_pix", pix, 1);
        one(3, 2, 1, lat, pix);   chk("c2_lat", lat, HITLAT);     chk("c2_pix", pix, 0);
        chk("c2_rdaddress", rdaddress, 80);
        pulse_inv();
        one(3, 1, 1, lat, pix);   chk("c3_lat", lat, 3);          chk("c3_pix", pix, 1);

        // All four requesters held continuously, fresh distinct bytes after each grant.
        ng = 0;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin x[10*i +: 10] = 10'(8 * (20 + i)); y[10*i +: 10] = 10'd2; end
        req = '1;
        for (int c = 0; c < 40 && gord.size() < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (ack[i]) begin gord.push_back(i); gcyc.push_back(cyc); end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (ack_seen[i]) begin
                ng++;
                x[10*i +: 10] = 10'(8 * (40 + ng)); y[10*i +: 10] = 10'd3;
            end
        end
        req = '0;
        drain();
        chk("rr_grants", gord.size(), 5);
        for (int k = 0; k < gord.size() && k < 5; k++) begin
            chk("rr_order", gord[k], k % N);
            if (k > 0) chk("rr_spacing", gcyc[k] - gcyc[k-1], 3);
        end

        // Reset while a miss is in flight.
        @(posedge clk); #1;
        x[9:0] = 10'd8; y[9:0] = 10'd0; req[0] = 1'b1;
        @(negedge clk);
        chk("rstflt_ack", ack, 1);
        @(posedge clk); #1 req[0] = 1'b0;
        #1 reset = 1'b0; req[1] = 1'b1;
        #1;
        chk("rstflt_rdaddress", rdaddress, 0);
        chk("rstflt_ack_forced", ack, 0);
        chk("rstflt_valid", valid, 0);
        chk("rstflt_pixel", pixel, 0);
        repeat (2) @(posedge clk);
        #1 req[1] = 1'b0; reset = 1'b1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (valid != 0) seen++; end
        chk("rstflt_no_valid", seen, 0);
        one(0, 8, 0, lat, pix);   chk("rstflt_re_lat", lat, 3);   chk("rstflt_re_pix", pix, 1);

        // Randomized requesters with occasional withdrawal and invalidate pulses.
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        pulse_inv();
        repeat (3000) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (ack_seen[i]) begin
                        if ($urandom_range(0, 1) == 1) new_xy(i);
                        else req[i] = 1'b0;
                    end else if ($urandom_range(0, 99) < 3) req[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 30) begin
                    new_xy(i); req[i] = 1'b1;
                end
            end
            invalidate = ($urandom_range(0, 99) < 5);
        end
        @(posedge clk); #1 req = '0; invalidate = 1'b0;
        drain();
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
